// File: rtl/calc3.sv
// calc3: single-cycle 32-bit arithmetic unit with a 32 x 32-bit register file.
// One command per cycle, one registered response per non-idle command
// (latency 1). Ports use MSB-first numbering: bit 0 is the MSB.
// Optional feature macro: CALC3_SHIFT_EN enables shl (0101) / shr (0110);
// without it both codes are answered as invalid commands and no shifter is built.
module calc3 (
    input  logic        c_clk,
    input  logic        reset,
    input  logic [0:3]  req1_cmd,
    input  logic [0:31] req1_data,
    input  logic [0:4]  req1_d1,
    input  logic [0:4]  req1_d2,
    input  logic [0:4]  req1_r1,
    input  logic [0:1]  req1_tag,
    output logic [0:1]  out1_resp,
    output logic [0:31] out1_data,
    output logic [0:1]  out1_tag
);

    typedef logic [0:31] word_t;

    localparam logic [0:3] CMD_IDLE  = 4'b0000;
    localparam logic [0:3] CMD_ADD   = 4'b0001;
    localparam logic [0:3] CMD_SUB   = 4'b0010;
`ifdef CALC3_SHIFT_EN
    localparam logic [0:3] CMD_SHL   = 4'b0101;
    localparam logic [0:3] CMD_SHR   = 4'b0110;
`endif
    localparam logic [0:3] CMD_STORE = 4'b1001;
    localparam logic [0:3] CMD_FETCH = 4'b1010;

    localparam logic [0:1] RESP_NONE = 2'b00;
    localparam logic [0:1] RESP_OK   = 2'b01;
    localparam logic [0:1] RESP_ERR  = 2'b10;

    // 33-bit unsigned sum; bit 0 (the MSB) is the carry-out
    function automatic logic [0:32] add_carry(input word_t a, input word_t b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    word_t       regfile_q [0:31];
    word_t       regfile_d [0:31];
    logic [0:1]  resp_p1_q, resp_p1_d;
    word_t       data_p1_q, data_p1_d;
    logic [0:1]  tag_p1_q,  tag_p1_d;

    word_t       op1;
    word_t       op2;
    logic [0:32] sum;

    // Decode and execute the sampled command: next register-file state and response
    always_comb begin
        regfile_d = regfile_q;
        resp_p1_d = RESP_NONE;
        data_p1_d = '0;
        tag_p1_d  = '0;
        // Operands come from the committed state, so r1 aliasing d1/d2 uses old values
        op1       = regfile_q[req1_d1];
        op2       = regfile_q[req1_d2];
        sum       = add_carry(op1, op2);

        if (req1_cmd != CMD_IDLE) begin
            tag_p1_d  = req1_tag;
            resp_p1_d = RESP_ERR;
            case (req1_cmd)
                CMD_ADD: begin
                    if (!sum[0]) begin
                        resp_p1_d          = RESP_OK;
                        data_p1_d          = sum[1:32];
                        regfile_d[req1_r1] = sum[1:32];
                    end
                end
                CMD_SUB: begin
                    if (op2 <= op1) begin
                        resp_p1_d          = RESP_OK;
                        data_p1_d          = op1 - op2;
                        regfile_d[req1_r1] = op1 - op2;
                    end
                end
`ifdef CALC3_SHIFT_EN
                CMD_SHL: begin
                    resp_p1_d          = RESP_OK;
                    data_p1_d          = op1 << op2[27:31];
                    regfile_d[req1_r1] = op1 << op2[27:31];
                end
                CMD_SHR: begin
                    resp_p1_d          = RESP_OK;
                    data_p1_d          = op1 >> op2[27:31];
                    regfile_d[req1_r1] = op1 >> op2[27:31];
                end
`endif
                CMD_STORE: begin
                    resp_p1_d          = RESP_OK;
                    regfile_d[req1_d1] = req1_data;
                end
                CMD_FETCH: begin
                    resp_p1_d = RESP_OK;
                    data_p1_d = op1;
                end
                default: begin
                    resp_p1_d = RESP_ERR;
                end
            endcase
        end
    end

    // Commit register writes and the response; reset clears everything and drops the command
    always_ff @(posedge c_clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regfile_q[i] <= '0;
            end
            resp_p1_q <= RESP_NONE;
            data_p1_q <= '0;
            tag_p1_q  <= '0;
        end else begin
            regfile_q <= regfile_d;
            resp_p1_q <= resp_p1_d;
            data_p1_q <= data_p1_d;
            tag_p1_q  <= tag_p1_d;
        end
    end

    // ---- stage p1: registered response ----
    assign out1_resp = resp_p1_q;
    assign out1_data = data_p1_q;
    assign out1_tag  = tag_p1_q;

endmodule

// File: tb/tb_calc3.sv
// Testbench for calc3: directed vector table, reset sequence and random
// commands checked against a behavioural model of the register file.
module tb_calc3;

    logic        c_clk;
    logic        reset;
    logic [0:3]  req1_cmd;
    logic [0:31] req1_data;
    logic [0:4]  req1_d1;
    logic [0:4]  req1_d2;
    logic [0:4]  req1_r1;
    logic [0:1]  req1_tag;
    logic [0:1]  out1_resp;
    logic [0:31] out1_data;
    logic [0:1]  out1_tag;

    int checks   = 0;
    int failures = 0;

    calc3 dut (
        .c_clk    (c_clk),
        .reset    (reset),
        .req1_cmd (req1_cmd),
        .req1_data(req1_data),
        .req1_d1  (req1_d1),
        .req1_d2  (req1_d2),
        .req1_r1  (req1_r1),
        .req1_tag (req1_tag),
        .out1_resp(out1_resp),
        .out1_data(out1_data),
        .out1_tag (out1_tag)
    );

    initial c_clk = 1'b0;
    always #5 c_clk = ~c_clk;

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] data;
        logic [4:0]  d1;
        logic [4:0]  d2;
        logic [4:0]  r1;
        logic [1:0]  tag;
        logic [1:0]  eresp;
        logic [31:0] edata;
        logic [1:0]  etag;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vec [NVEC];

    // Behavioural model state
    logic [31:0] m_regs [32];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    endtask

    // Command semantics written directly from the arithmetic rules
    task automatic model_exec(input logic [3:0] c, input logic [31:0] dat,
                              input logic [4:0] a, input logic [4:0] b, input logic [4:0] r,
                              input logic [1:0] t,
                              output logic [1:0] er, output logic [31:0] ed, output logic [1:0] et);
        longint unsigned x, y, s;
        x  = m_regs[a];
        y  = m_regs[b];
        er = 2'b10;
        ed = 32'd0;
        et = t;
        if (c == 4'd0) begin
            er = 2'b00;
            et = 2'b00;
        end else if (c == 4'd1) begin
            s = x + y;
            if (s <= 64'hFFFF_FFFF) begin er = 2'b01; ed = s[31:0]; m_regs[r] = s[31:0]; end
        end else if (c == 4'd2) begin
            if (y <= x) begin s = x - y; er = 2'b01; ed = s[31:0]; m_regs[r] = s[31:0]; end
`ifdef CALC3_SHIFT_EN
        end else if (c == 4'd5) begin
            s = (x * (64'd1 << (y % 32))) % 64'h1_0000_0000;
            er = 2'b01; ed = s[31:0]; m_regs[r] = s[31:0];
        end else if (c == 4'd6) begin
            s = x / (64'd1 << (y % 32));
            er = 2'b01; ed = s[31:0]; m_regs[r] = s[31:0];
`endif
        end else if (c == 4'd9) begin
            er = 2'b01; m_regs[a] = dat;
        end else if (c == 4'd10) begin
            er = 2'b01; ed = x[31:0];
        end
    endtask

    // Present one command, let it be sampled, and read the response 1 ns later
    task automatic issue(input logic [3:0] c, input logic [31:0] dat,
                         input logic [4:0] a, input logic [4:0] b, input logic [4:0] r,
                         input logic [1:0] t,
                         output logic [1:0] ar, output logic [31:0] ad, output logic [1:0] at);
        req1_cmd  = c;
        req1_data = dat;
        req1_d1   = a;
        req1_d2   = b;
        req1_r1   = r;
        req1_tag  = t;
        @(posedge c_clk);
        #1;
        ar = out1_resp;
        ad = out1_data;
        at = out1_tag;
    endtask

    logic [1:0]  ar, at, er, et;
    logic [31:0] ad, ed;
    logic [3:0]  cmd_pool [9];

    initial begin
        // Directed vectors: {cmd, data, d1, d2, r1, tag, resp, data, tag}
        vec[0]  = '{4'd9,  32'd10,         5'd1,  5'd0,  5'd0,  2'd0, 2'b01, 32'd0,  2'd0};
        vec[1]  = '{4'd9,  32'd15,         5'd2,  5'd0,  5'd0,  2'd1, 2'b01, 32'd0,  2'd1};
        vec[2]  = '{4'd1,  32'd0,          5'd1,  5'd2,  5'd3,  2'd2, 2'b01, 32'd25, 2'd2};
        vec[3]  = '{4'd10, 32'd0,          5'd3,  5'd0,  5'd0,  2'd3, 2'b01, 32'd25, 2'd3};
        vec[4]  = '{4'd9,  32'hFFFF_FFFF,  5'd4,  5'd0,  5'd0,  2'd0, 2'b01, 32'd0,  2'd0};
        vec[5]  = '{4'd9,  32'd1,          5'd5,  5'd0,  5'd0,  2'd1, 2'b01, 32'd0,  2'd1};
        vec[6]  = '{4'd1,  32'd0,          5'd4,  5'd5,  5'd6,  2'd2, 2'b10, 32'd0,  2'd2};
        vec[7]  = '{4'd10, 32'd0,          5'd6,  5'd0,  5'd0,  2'd3, 2'b01, 32'd0,  2'd3};
        vec[8]  = '{4'd9,  32'd3,          5'd7,  5'd0,  5'd0,  2'd0, 2'b01, 32'd0,  2'd0};
        vec[9]  = '{4'd9,  32'd5,          5'd8,  5'd0,  5'd0,  2'd1, 2'b01, 32'd0,  2'd1};
        vec[10] = '{4'd2,  32'd0,          5'd7,  5'd8,  5'd9,  2'd2, 2'b10, 32'd0,  2'd2};
        vec[11] = '{4'd2,  32'd0,          5'd8,  5'd7,  5'd9,  2'd3, 2'b01, 32'd2,  2'd3};
        vec[12] = '{4'd9,  32'd1,          5'd10, 5'd0,  5'd0,  2'd0, 2'b01, 32'd0,  2'd0};
        vec[13] = '{4'd9,  32'd33,         5'd11, 5'd0,  5'd0,  2'd1, 2'b01, 32'd0,  2'd1};
`ifdef CALC3_SHIFT_EN
        vec[14] = '{4'd5,  32'd0,          5'd10, 5'd11, 5'd13, 2'd2, 2'b01, 32'd2,  2'd2};
`else
        vec[14] = '{4'd5,  32'd0,          5'd10, 5'd11, 5'd13, 2'd2, 2'b10, 32'd0,  2'd2};
`endif
        vec[15] = '{4'd9,  32'h8000_0000,  5'd14, 5'd0,  5'd0,  2'd3, 2'b01, 32'd0,  2'd3};
        vec[16] = '{4'd9,  32'd31,         5'd15, 5'd0,  5'd0,  2'd0, 2'b01, 32'd0,  2'd0};
`ifdef CALC3_SHIFT_EN
        vec[17] = '{4'd6,  32'd0,          5'd14, 5'd15, 5'd16, 2'd1, 2'b01, 32'd1,  2'd1};
`else
        vec[17] = '{4'd6,  32'd0,          5'd14, 5'd15, 5'd16, 2'd1, 2'b10, 32'd0,  2'd1};
`endif
        vec[18] = '{4'd15, 32'd0,          5'd9,  5'd9,  5'd9,  2'd2, 2'b10, 32'd0,  2'd2};
        vec[19] = '{4'd10, 32'd0,          5'd9,  5'd0,  5'd0,  2'd0, 2'b01, 32'd2,  2'd0};
        vec[20] = '{4'd0,  32'd0,          5'd1,  5'd2,  5'd3,  2'd3, 2'b00, 32'd0,  2'd0};

        cmd_pool = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd6, 4'd9, 4'd10, 4'd3, 4'd15};

        // Reset state
        reset = 1'b1;
        req1_cmd = '0; req1_data = '0; req1_d1 = '0; req1_d2 = '0; req1_r1 = '0; req1_tag = '0;
        model_reset();
        repeat (2) @(posedge c_clk);
        #1;
        check("rst_resp", {30'd0, out1_resp}, 32'd0);
        check("rst_data", out1_data, 32'd0);
        check("rst_tag",  {30'd0, out1_tag}, 32'd0);
        reset = 1'b0;

        // Directed table, back-to-back
        for (int i = 0; i < NVEC; i++) begin
            issue(vec[i].cmd, vec[i].data, vec[i].d1, vec[i].d2, vec[i].r1, vec[i].tag, ar, ad, at);
            model_exec(vec[i].cmd, vec[i].data, vec[i].d1, vec[i].d2, vec[i].r1, vec[i].tag, er, ed, et);
            check($sformatf("vec%0d_resp", i), {30'd0, ar}, {30'd0, vec[i].eresp});
            check($sformatf("vec%0d_data", i), ad, vec[i].edata);
            check($sformatf("vec%0d_tag", i),  {30'd0, at}, {30'd0, vec[i].etag});
        end

        // Reset discards commands presented during it and clears the register file
        issue(4'd9, 32'd7, 5'd12, 5'd0, 5'd0, 2'd1, ar, ad, at);
        model_exec(4'd9, 32'd7, 5'd12, 5'd0, 5'd0, 2'd1, er, ed, et);
        check("pre_rst_store", {30'd0, ar}, 32'd1);
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            issue(4'd9, 32'd99, 5'd12, 5'd0, 5'd0, 2'd3, ar, ad, at);
            check($sformatf("in_rst%0d_resp", i), {30'd0, ar}, 32'd0);
            check($sformatf("in_rst%0d_data", i), ad, 32'd0);
            check($sformatf("in_rst%0d_tag", i),  {30'd0, at}, 32'd0);
        end
        model_reset();
        reset = 1'b0;
        issue(4'd10, 32'd0, 5'd12, 5'd0, 5'd0, 2'd2, ar, ad, at);
        check("post_rst_fetch_resp", {30'd0, ar}, 32'd1);
        check("post_rst_fetch_data", ad, 32'd0);
        check("post_rst_fetch_tag",  {30'd0, at}, 32'd2);

        // Random commands against the model, small index range to force aliasing
        for (int n = 0; n < 400; n++) begin
            logic [3:0]  c;
            logic [31:0] dat;
            logic [4:0]  a, b, r;
            logic [1:0]  t;
            c = cmd_pool[$urandom_range(0, 8)];
            case ($urandom_range(0, 3))
                0: dat = $urandom;
                1: dat = 32'hFFFF_FFFF - $urandom_range(0, 3);
                2: dat = $urandom_range(0, 40);
                default: dat = 32'h8000_0000 >> $urandom_range(0, 31);
            endcase
            a = 5'($urandom_range(0, 7));
            b = 5'($urandom_range(0, 7));
            r = 5'($urandom_range(0, 7));
            t = 2'($urandom_range(0, 3));
            issue(c, dat, a, b, r, t, ar, ad, at);
            model_exec(c, dat, a, b, r, t, er, ed, et);
            check($sformatf("rnd%0d_resp", n), {30'd0, ar}, {30'd0, er});
            check($sformatf("rnd%0d_data", n), ad, ed);
            check($sformatf("rnd%0d_tag", n),  {30'd0, at}, {30'd0, et});
        end

        // Sweep every register back out and compare with the model
        for (int i = 0; i < 32; i++) begin
            issue(4'd10, 32'd0, 5'(i), 5'd0, 5'd0, 2'd1, ar, ad, at);
            model_exec(4'd10, 32'd0, 5'(i), 5'd0, 5'd0, 2'd1, er, ed, et);
            check($sformatf("final_r%0d", i), ad, ed);
        end

        req1_cmd = '0;
        @(posedge c_clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
